dmem_ctrl: RTL and testbench

Parametrised data memory with a request/ready handshake for the 8-bit datapath, replacing the fixed 256x8 data memory. It adds a hardware clear sequence after reset, a registered read with a one-cycle `rvalid` pulse, forwarding of write data to a same-cycle read, and an error flag for bad requests. It sits between the load/store unit and the storage array. All outputs are driven at all times; there is no tri-state.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_ctrl.sv | 109 ++++++++++
 tb/tb_dmem_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory controller.
package dmem_pkg;

  localparam int DMEM_DW    = 8;
  localparam int DMEM_AW    = 8;
  localparam int DMEM_DEPTH = 256;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_t;

  // Width of the clear counter / internal word index.
  function automatic int clr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DW storage: one synchronous write port, one combinational read port.
// Contents are not reset; the controller clears them after reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DW    = DMEM_DW,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int CW    = clr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [CW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [CW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Single write port on the rising edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: clears the array after reset, then serves one
// read/write request per cycle with registered, one-cycle-latency responses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DW    = DMEM_DW,
  parameter int AW    = DMEM_AW,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          err,
  output logic          init_done
);

  localparam int            CW   = clr_w(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  dmem_state_t   state, state_nxt;
  logic [CW-1:0] clr_addr;
  logic          oor, acc;
  logic          mem_we;
  logic [CW-1:0] mem_waddr, req_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // In-range addresses always fit in CW bits; out-of-range ones never
  // touch the array (write gated, read data masked).
  assign req_addr = addr[CW-1:0];

  // A full 2^AW array has no out-of-range addresses; skip the compare.
  generate
    if (DEPTH >= (1 << AW)) begin : g_full
      assign oor = 1'b0;
    end else begin : g_part
      assign oor = (addr >= AW'(DEPTH));
    end
  endgenerate

  assign acc = ready & (rd | wr);

  // State register and clear counter (counter holds at LAST once done).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT && clr_addr != LAST) clr_addr <= clr_addr + 1'b1;
    end
  end

  // Leave INIT in the same edge that clears the last word.
  always_comb begin
    state_nxt = state;
    if (state == INIT && clr_addr == LAST) state_nxt = RUN;
  end

  // Array write mux: clear sweep in INIT, accepted in-range writes in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = req_addr;
    mem_wdata = wdata;
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = '0;
      end
      RUN: mem_we = acc & wr & ~oor;
      default: mem_we = 1'b0;
    endcase
  end

  dmem_array #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (req_addr),
    .rdata (mem_rdata)
  );

  // Registered outputs; ready/init_done lag RUN by one cycle. A read that
  // coincides with a write returns the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready     <= 1'b0;
      init_done <= 1'b0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      ready     <= (state == RUN);
      init_done <= (state == RUN);
      rvalid    <= acc & rd;
      err       <= acc & oor;
      if (acc && rd && !oor) rdata <= wr ? wdata : mem_rdata;
      else                   rdata <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench: a full-depth (256) and a partial-depth (200) instance
// share stimulus and are compared against a per-instance behavioural model.
module tb_dmem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd = 1'b0, wr = 1'b0;
  logic [7:0] addr = '0, wdata = '0;

  logic       ready_o [2];
  logic       rvalid_o[2];
  logic       err_o   [2];
  logic       init_o  [2];
  logic [7:0] rdata_o [2];

  always #5 clk = ~clk;

  dmem_ctrl #(.DW(8), .AW(8), .DEPTH(256)) u_big (
    .clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready_o[0]), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]),
    .err(err_o[0]), .init_done(init_o[0])
  );

  dmem_ctrl #(.DW(8), .AW(8), .DEPTH(200)) u_small (
    .clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready_o[1]), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]),
    .err(err_o[1]), .init_done(init_o[1])
  );

  // Reference model: memory image, edges since reset release, expected outputs.
  int         dep[2] = '{256, 200};
  logic [7:0] mm[2][256];
  int         cnt[2];
  logic [7:0] e_rdata[2];
  logic       e_rvalid[2], e_err[2];
  int         n_pass = 0, n_tot = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s dut%0d got=%0h exp=%0h", tag, k, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; e_rdata[k] = '0; e_rvalid[k] = 1'b0; e_err[k] = 1'b0;
      for (int a = 0; a < 256; a++) mm[k][a] = '0;
    end
  endtask

  task automatic check_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, ".rdata"},  k, rdata_o[k],  e_rdata[k]);
      chk({tag, ".rvalid"}, k, rvalid_o[k], e_rvalid[k]);
      chk({tag, ".err"},    k, err_o[k],    e_err[k]);
      chk({tag, ".ready"},  k, ready_o[k],  cnt[k] >= dep[k] + 1);
      chk({tag, ".init"},   k, init_o[k],   cnt[k] >= dep[k] + 1);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, check 1 unit later.
  task automatic step(input string tag, input logic r, input logic w,
                      input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (cnt[k] >= dep[k] + 1 && (r || w)) begin
        logic bad;
        bad         = (int'(a) >= dep[k]);
        e_rvalid[k] = r;
        e_err[k]    = bad;
        e_rdata[k]  = (r && !bad) ? (w ? d : mm[k][a]) : 8'h00;
        if (w && !bad) mm[k][a] = d;
      end else begin
        e_rvalid[k] = 1'b0; e_err[k] = 1'b0; e_rdata[k] = 8'h00;
      end
      cnt[k]++;
    end
    #1 check_outs(tag);
  endtask

  initial begin
    int n;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_outs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Clear sequence with writes attempted while not ready
    n = 0;
    while (ready_o[0] !== 1'b1 && n < 400) begin
      step("init", 1'b0, n < 190, 8'($urandom), 8'($urandom));
      n++;
    end
    chk("ready_edges", 0, n, 257);

    step("rd_a5", 1'b1, 1'b0, 8'hA5, 8'h00);
    step("wr_10", 1'b0, 1'b1, 8'h10, 8'h3C);
    step("rd_10", 1'b1, 1'b0, 8'h10, 8'h00);
    step("idle",  1'b0, 1'b0, 8'h10, 8'hFF);
    step("rw_20", 1'b1, 1'b1, 8'h20, 8'h99);
    step("rd_20", 1'b1, 1'b0, 8'h20, 8'h00);
    step("wr_c8", 1'b0, 1'b1, 8'hC8, 8'h55);
    step("rd_c8", 1'b1, 1'b0, 8'hC8, 8'h00);
    step("rw_ff", 1'b1, 1'b1, 8'hFF, 8'h12);
    step("rd_c7", 1'b1, 1'b0, 8'hC7, 8'h00);

    // Every address: INIT-time writes must have been dropped
    for (int a = 0; a < 256; a++) step("sweep", 1'b1, 1'b0, 8'(a), 8'h00);

    // Random traffic, back-to-back
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));

    // Reset in the middle of a read burst
    step("wr_05", 1'b0, 1'b1, 8'h05, 8'h77);
    step("rd_05", 1'b1, 1'b0, 8'h05, 8'h00);
    step("rd_06", 1'b1, 1'b0, 8'h06, 8'h00);
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_outs("async_reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (ready_o[0] !== 1'b1 && n < 400) begin
      step("reinit", 1'b1, 1'b1, 8'h05, 8'hEE);
      n++;
    end
    chk("ready_edges2", 0, n, 257);
    step("rd_05_clr", 1'b1, 1'b0, 8'h05, 8'h00);
    step("rd_06_clr", 1'b1, 1'b0, 8'h06, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
